pattern_player: RTL and testbench

PATTERN_PLAYER -- requirements
Module: pattern_player

---
 rtl/pattern_player.sv | 138 +++++++++++++
 tb/tb_pattern_player.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_player.sv
// pattern_player: plays a latched bit pattern oldest-first, one bit per SHOW/GAP slot.
// Optional feature: define PATTERN_PLAYER_REPLAY_EN to add the replay input.
module pattern_player #(
   parameter int unsigned BIT_TICKS = 50,
   parameter int unsigned GAP_TICKS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] pattern,
   input  logic [15:0] length,
`ifdef PATTERN_PLAYER_REPLAY_EN
   input  logic        replay,
`endif
   output logic        busy,
   output logic        led_valid,
   output logic        led_bit,
   output logic [4:0]  bit_index,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHOW,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [15:0] LP_BIT_LD = 16'(BIT_TICKS - 1);
   localparam logic [15:0] LP_GAP_LD = 16'(GAP_TICKS - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [4:0]  r_idx;
   logic [31:0] r_pat;
   logic [5:0]  r_len;

   state_t      w_state;
   logic [15:0] w_cnt;
   logic [4:0]  w_idx;
   logic [31:0] w_pat;
   logic [5:0]  w_len;

   logic        w_go;
   logic [5:0]  w_eff_len;
   logic [5:0]  w_sel_len;

   assign w_eff_len = (length > 16'd32) ? 6'd32 : length[5:0];

`ifdef PATTERN_PLAYER_REPLAY_EN
   // start takes precedence; replay reuses the previously latched length
   assign w_go      = start | replay;
   assign w_sel_len = start ? w_eff_len : r_len;
`else
   assign w_go      = start;
   assign w_sel_len = w_eff_len;
`endif

   // state register and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_idx   <= 5'd0;
         r_pat   <= 32'd0;
         r_len   <= 6'd0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_pat   <= w_pat;
         r_len   <= w_len;
      end
   end

   // next-state, counter reload on each state entry, latch on start
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_pat   = r_pat;
      w_len   = r_len;
      unique case (r_state)
         S_IDLE: begin
            if (w_go) begin
               if (start) begin
                  w_pat = pattern;
                  w_len = w_eff_len;
               end
               if (w_sel_len == 6'd0) begin
                  w_state = S_DONE;
                  w_cnt   = 16'd0;
               end else begin
                  w_state = S_SHOW;
                  w_cnt   = LP_BIT_LD;
                  w_idx   = 5'(w_sel_len - 6'd1);
               end
            end
         end
         S_SHOW: begin
            if (r_cnt == 16'd0) begin
               w_state = S_GAP;
               w_cnt   = LP_GAP_LD;
            end else begin
               w_cnt = r_cnt - 16'd1;
            end
         end
         S_GAP: begin
            if (r_cnt == 16'd0) begin
               if (r_idx == 5'd0) begin
                  w_state = S_DONE;
                  w_cnt   = 16'd0;
               end else begin
                  w_state = S_SHOW;
                  w_cnt   = LP_BIT_LD;
                  w_idx   = r_idx - 5'd1;
               end
            end else begin
               w_cnt = r_cnt - 16'd1;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_cnt   = 16'd0;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign busy      = (r_state != S_IDLE);
   assign led_valid = (r_state == S_SHOW);
   assign led_bit   = led_valid & r_pat[r_idx];
   assign bit_index = r_idx;
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player: directed playback scenarios for pattern_player
// with BIT_TICKS=4, GAP_TICKS=2.
module tb_pattern_player;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] pattern;
   logic [15:0] length;
`ifdef PATTERN_PLAYER_REPLAY_EN
   logic        replay;
`endif
   logic        busy;
   logic        led_valid;
   logic        led_bit;
   logic [4:0]  bit_index;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m_seq;
   int m_nper, m_first_idx, m_first_valid, m_lat, m_ndone, m_busy;
   int m_smin, m_smax, m_gmin, m_gmax, m_bad;

   pattern_player #(
      .BIT_TICKS(4),
      .GAP_TICKS(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pattern   (pattern),
      .length    (length),
`ifdef PATTERN_PLAYER_REPLAY_EN
      .replay    (replay),
`endif
      .busy      (busy),
      .led_valid (led_valid),
      .led_bit   (led_bit),
      .bit_index (bit_index),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                  tag, got, got, exp, exp);
      end
   endtask

   // mode 0: plain, 1: disturb mid-run, 2: reset in 2nd SHOW, 3: replay
   task automatic play(input logic [31:0] p, input logic [15:0] l,
                       input int mode);
      int  run_s, run_g, last_idx, post;
      bit  prev_v, seen_done, rst_issued;
      m_seq = '0; m_nper = 0; m_first_idx = -1; m_first_valid = -1;
      m_lat = -1; m_ndone = 0; m_busy = 0; m_bad = 0;
      m_smin = 9999; m_smax = 0; m_gmin = 9999; m_gmax = 0;
      run_s = 0; run_g = 0; last_idx = 0; post = 0;
      prev_v = 0; seen_done = 0; rst_issued = 0;
      pattern = p;
      length  = l;
`ifdef PATTERN_PLAYER_REPLAY_EN
      if (mode == 3) replay = 1'b1;
      else start = 1'b1;
`else
      start = 1'b1;
`endif
      @(posedge clk); #1;
      start = 1'b0;
`ifdef PATTERN_PLAYER_REPLAY_EN
      replay = 1'b0;
`endif
      for (int c = 0; c < 2000; c++) begin
         if (rst_issued) begin
            chk("rst_abort_outs",
                {busy, led_valid, led_bit, bit_index, done}, 0);
            rst = 1'b0;
            return;
         end
         if (mode == 1 && c == 7) begin
            start   = 1'b1;
            pattern = ~p;
            length  = 16'd5;
         end
         if (mode == 1 && c == 8) start = 1'b0;
         if (led_valid && !prev_v) begin
            m_nper++;
            m_seq = {m_seq[62:0], led_bit};
            if (m_first_idx < 0) m_first_idx = int'(bit_index);
            else if (int'(bit_index) != last_idx - 1) m_bad++;
            last_idx = int'(bit_index);
            if (m_first_valid < 0) m_first_valid = c;
            if (run_g > 0) begin
               if (run_g < m_gmin) m_gmin = run_g;
               if (run_g > m_gmax) m_gmax = run_g;
            end
            run_g = 0;
         end
         if (led_valid) begin
            run_s++;
            if (led_bit != m_seq[0]) m_bad++;
            if (int'(bit_index) != last_idx) m_bad++;
         end else begin
            if (run_s > 0) begin
               if (run_s < m_smin) m_smin = run_s;
               if (run_s > m_smax) m_smax = run_s;
            end
            run_s = 0;
            if (led_bit) m_bad++;
            if (busy && !done) run_g++;
         end
         prev_v = led_valid;
         if (busy) m_busy++;
         if (done) begin
            m_ndone++;
            if (!seen_done)
               m_lat = c - ((m_first_valid < 0) ? 0 : m_first_valid);
            if (run_g > 0) begin
               if (run_g < m_gmin) m_gmin = run_g;
               if (run_g > m_gmax) m_gmax = run_g;
            end
            run_g = 0;
            seen_done = 1;
         end
         if (mode == 2 && m_nper == 2 && !rst_issued) begin
            rst = 1'b1;
            rst_issued = 1;
         end
         if (seen_done) post++;
         if (post > 4) break;
         @(posedge clk); #1;
      end
      if (mode != 2) chk("done_seen", seen_done, 1);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      pattern = '0;
      length  = '0;
`ifdef PATTERN_PLAYER_REPLAY_EN
      replay  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", led_valid, 0);
      chk("rst_bit", led_bit, 0);
      chk("rst_idx", bit_index, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

`ifdef PATTERN_PLAYER_REPLAY_EN
      play(32'h0000_FFFF, 16'd4, 3);
      chk("rpl_rst_nper", m_nper, 0);
      chk("rpl_rst_lat", m_lat, 0);
`endif

      play(32'h5, 16'd3, 0);
      chk("s1_seq", m_seq, 5);
      chk("s1_nper", m_nper, 3);
      chk("s1_first_idx", m_first_idx, 2);
      chk("s1_first_valid", m_first_valid, 0);
      chk("s1_lat", m_lat, 18);
      chk("s1_ndone", m_ndone, 1);
      chk("s1_busy", m_busy, 19);
      chk("s1_show_min", m_smin, 4);
      chk("s1_show_max", m_smax, 4);
      chk("s1_gap_min", m_gmin, 2);
      chk("s1_gap_max", m_gmax, 2);
      chk("s1_bad", m_bad, 0);
      chk("s1_idx_hold", bit_index, 0);

      play(32'hFFFF_FFFF, 16'd0, 0);
      chk("z_nper", m_nper, 0);
      chk("z_lat", m_lat, 0);
      chk("z_ndone", m_ndone, 1);
      chk("z_busy", m_busy, 1);

      play(32'hFFFF_FFFF, 16'd40, 0);
      chk("l40_nper", m_nper, 32);
      chk("l40_first_idx", m_first_idx, 31);
      chk("l40_seq", m_seq, 64'hFFFF_FFFF);
      chk("l40_lat", m_lat, 192);
      chk("l40_bad", m_bad, 0);

      play(32'h8000_0001, 16'd32, 0);
      chk("l32_seq", m_seq, 64'h8000_0001);
      chk("l32_nper", m_nper, 32);

      play(32'h0000_00A5, 16'd8, 0);
      chk("a5_seq", m_seq, 64'hA5);
      chk("a5_bad", m_bad, 0);

      play(32'h0, 16'd1, 0);
      chk("l1_nper", m_nper, 1);
      chk("l1_seq", m_seq, 0);
      chk("l1_lat", m_lat, 6);

      play(32'h5, 16'd3, 1);
      chk("dist_seq", m_seq, 5);
      chk("dist_nper", m_nper, 3);
      chk("dist_lat", m_lat, 18);
      chk("dist_ndone", m_ndone, 1);
      chk("dist_bad", m_bad, 0);

      play(32'h5, 16'd3, 2);
      chk("abort_ndone", m_ndone, 0);
      play(32'h5, 16'd3, 0);
      chk("after_rst_seq", m_seq, 5);
      chk("after_rst_first", m_first_valid, 0);
      chk("after_rst_lat", m_lat, 18);

      rst     = 1'b1;
      start   = 1'b1;
      pattern = 32'h5;
      length  = 16'd3;
      @(posedge clk); #1;
      chk("rst_prio", {busy, led_valid, done}, 0);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk("rst_prio_idle", busy, 0);

`ifdef PATTERN_PLAYER_REPLAY_EN
      play(32'h2, 16'd2, 0);
      chk("rpl_base_seq", m_seq, 2);
      play(32'h0, 16'd2, 3);
      chk("rpl_seq", m_seq, 2);
      chk("rpl_nper", m_nper, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
